// File: rtl/demux_frame_serializer_if.sv
// Handshake and serial-output bundle for demux_frame_serializer.
//   master : upstream side, drives in_valid/in_addr/in_data and observes the
//            serial outputs (used by the testbench).
//   slave  : the serializer itself.
// Signals:
//   in_valid/in_ready : word handshake; a word is accepted on a rising edge
//                       when both are high.
//   in_addr           : destination channel 0..3.
//   in_data           : parallel word, shifted out MSB-first.
//   sel, din, frame, done : registered outputs toward the 1-to-4 demux.
interface demux_frame_serializer_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_addr;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        sel;
    logic              din;
    logic              frame;
    logic              done;

    modport master (
        output in_valid, in_addr, in_data,
        input  in_ready, sel, din, frame, done
    );

    modport slave (
        input  in_valid, in_addr, in_data,
        output in_ready, sel, din, frame, done
    );
endinterface

// File: rtl/demux_frame_serializer.sv
// Upstream driver for a 1-to-4 serial demultiplexer.
// Accepts a word plus a 2-bit channel over valid/ready, holds sel for the
// whole frame and shifts the word out MSB-first on din with a frame strobe,
// followed by a one-cycle done pulse and GAP_CYCLES idle cycles.
// Ports:
//   clk  : system clock, rising edge.
//   rst  : asynchronous, active-high reset.
//   bus  : slave side of demux_frame_serializer_if (handshake + outputs).
module demux_frame_serializer #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    demux_frame_serializer_if.slave  bus
);
    localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] sr, sr_n;
    logic [CW-1:0]     bcnt, bcnt_n;
    logic [3:0]        gcnt, gcnt_n;
    logic [1:0]        sel_q, sel_n;
    logic              din_q, din_n;
    logic              frame_q, frame_n;
    logic              done_q, done_n;

    assign bus.in_ready = (state == IDLE) && !rst;
    assign bus.sel      = sel_q;
    assign bus.din      = din_q;
    assign bus.frame    = frame_q;
    assign bus.done     = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            bcnt    <= '0;
            gcnt    <= '0;
            sel_q   <= '0;
            din_q   <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            bcnt    <= bcnt_n;
            gcnt    <= gcnt_n;
            sel_q   <= sel_n;
            din_q   <= din_n;
            frame_q <= frame_n;
            done_q  <= done_n;
        end
    end

    // Outputs are registered, so each branch computes what the pins must
    // show during the *next* cycle. din always mirrors the next shift
    // register MSB while a frame is on the line.
    always_comb begin
        state_n = state;
        sr_n    = sr;
        bcnt_n  = bcnt;
        gcnt_n  = gcnt;
        sel_n   = sel_q;
        din_n   = 1'b0;
        frame_n = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sr_n    = bus.in_data;
                    sel_n   = bus.in_addr;
                    bcnt_n  = CW'(DATA_W - 1);
                    din_n   = bus.in_data[DATA_W-1];
                    frame_n = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sr_n = sr << 1;
                if (bcnt == '0) begin
                    // Last bit has been on the line: close the frame.
                    done_n  = 1'b1;
                    gcnt_n  = 4'(GAP_CYCLES - 1);
                    state_n = GAP;
                end else begin
                    bcnt_n  = bcnt - CW'(1);
                    din_n   = sr_n[DATA_W-1];
                    frame_n = 1'b1;
                end
            end
            GAP: begin
                if (gcnt == 4'd0) state_n = IDLE;
                else              gcnt_n  = gcnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_demux_frame_serializer.sv
// Self-checking bench for demux_frame_serializer. Two configurations run in
// parallel (DATA_W=8/GAP=1 and DATA_W=4/GAP=3), each with its own reset,
// stimulus, frame-queue reference model and per-cycle compare.
module tb_demux_frame_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic       din;
        logic       frame;
        logic       done;
        logic       idle;
    } exp_t;

    for (genvar K = 0; K < 2; K++) begin : cfg
        localparam int DW = (K == 0) ? 8 : 4;
        localparam int GP = (K == 0) ? 1 : 3;

        logic rst = 1'b0;
        int   errs = 0, chks = 0, cerr = 0, cchk = 0;
        bit   fin = 1'b0;

        demux_frame_serializer_if #(.DATA_W(DW)) bus ();

        demux_frame_serializer #(.DATA_W(DW), .GAP_CYCLES(GP)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Reference model: an accept queues the whole frame's per-cycle
        // outputs (DW data cycles, then GP gap cycles with done on the
        // first); an empty queue means idle with sel held.
        exp_t q[$];
        exp_t cur = '{sel: 2'd0, din: 1'b0, frame: 1'b0, done: 1'b0, idle: 1'b1};

        initial forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                cur = '{sel: 2'd0, din: 1'b0, frame: 1'b0, done: 1'b0, idle: 1'b1};
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else if (cur.idle && bus.in_valid) begin
                for (int i = DW - 1; i >= 0; i--)
                    q.push_back('{sel: bus.in_addr, din: bus.in_data[i], frame: 1'b1, done: 1'b0, idle: 1'b0});
                for (int g = 0; g < GP; g++)
                    q.push_back('{sel: bus.in_addr, din: 1'b0, frame: 1'b0, done: (g == 0), idle: 1'b0});
                cur = q.pop_front();
            end else begin
                cur = '{sel: cur.sel, din: 1'b0, frame: 1'b0, done: 1'b0, idle: 1'b1};
            end
        end

        initial forever begin
            logic [5:0] act, exp;
            @(negedge clk);
            act = {bus.in_ready, bus.sel, bus.din, bus.frame, bus.done};
            exp = {cur.idle && !rst, cur.sel, cur.din, cur.frame, cur.done};
            cchk++;
            if (act !== exp) begin
                cerr++;
                $display("FAIL cmp cfg%0d t=%0t {rdy,sel,din,frame,done} got %b expected %b", K, $time, act, exp);
            end
        end

        task automatic chk(input string nm, input int act, input int exp);
            chks++;
            if (act != exp) begin
                errs++;
                $display("FAIL %s cfg%0d: got %0d expected %0d", nm, K, act, exp);
            end
        endtask

        task automatic step();
            @(posedge clk);
            #2;
        endtask

        initial begin
            logic [31:0] word, exp_word;
            int acc[2];
            int na;
            bus.in_valid = 1'b0;
            bus.in_addr  = 2'd0;
            bus.in_data  = '0;
            #1 rst = 1'b1;
            #1 chk("rdy_in_rst", bus.in_ready, 0);
            repeat (3) step();
            rst = 1'b0;
            @(negedge clk);
            chk("rdy_after_rst", bus.in_ready, 1);
            chk("sel_after_rst", bus.sel, 0);
            step();

            // Single frame with literal expectations.
            exp_word     = (K == 0) ? 32'hA5 : 32'h9;
            bus.in_valid = 1'b1;
            bus.in_addr  = (K == 0) ? 2'd2 : 2'd1;
            bus.in_data  = DW'(exp_word);
            step();
            bus.in_valid = 1'b0;
            bus.in_addr  = 2'd0;
            bus.in_data  = ~bus.in_data;
            word = '0;
            for (int i = 0; i < DW; i++) begin
                @(negedge clk);
                word[DW-1-i] = bus.din;
                chk("frame_hi", bus.frame, 1);
            end
            chk("word_bits", int'(word), int'(exp_word));
            chk("sel_frame", bus.sel, (K == 0) ? 2 : 1);
            @(negedge clk);
            chk("done_pulse", {bus.done, bus.frame, bus.in_ready}, 3'b100);
            repeat (GP) @(negedge clk);
            chk("rdy_after_gap", bus.in_ready, 1);
            chk("done_cleared", bus.done, 0);
            step();

            // Back-to-back with in_valid held: accept spacing.
            bus.in_valid = 1'b1;
            bus.in_addr  = 2'd1;
            bus.in_data  = '1;
            na = 0;
            for (int n = 0; n < 40 && na < 2; n++) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    acc[na] = n;
                    na++;
                end
                step();
                if (na == 1) begin
                    bus.in_addr = 2'd3;
                    bus.in_data = DW'(1);
                end
            end
            bus.in_valid = 1'b0;
            chk("b2b_accepts", na, 2);
            if (na == 2) chk("b2b_period", acc[1] - acc[0], (K == 0) ? 10 : 8);
            repeat (20) step();

            // Reset in the middle of a frame.
            bus.in_valid = 1'b1;
            bus.in_addr  = 2'd2;
            bus.in_data  = DW'(32'hA5);
            step();
            bus.in_valid = 1'b0;
            step();
            step();
            rst = 1'b1;
            #1 chk("rst_mid", {bus.sel, bus.din, bus.frame, bus.in_ready, bus.done}, 0);
            step();
            rst = 1'b0;
            @(negedge clk);
            chk("rdy_after_mid_rst", {bus.in_ready, bus.done}, 2'b10);
            step();

            // Reset in the second gap cycle.
            bus.in_valid = 1'b1;
            bus.in_addr  = 2'd3;
            bus.in_data  = DW'($urandom);
            step();
            bus.in_valid = 1'b0;
            repeat (DW + 1) step();
            rst = 1'b1;
            #1 chk("rst_gap", {bus.sel, bus.done, bus.frame}, 0);
            step();
            rst = 1'b0;
            @(negedge clk);
            chk("after_gap_rst", {bus.in_ready, bus.sel, bus.done}, 4'b1000);
            step();

            // Random traffic with input churn and occasional resets.
            for (int n = 0; n < 1500; n++) begin
                bus.in_valid = ($urandom_range(0, 2) != 0);
                bus.in_addr  = 2'($urandom);
                bus.in_data  = DW'($urandom);
                rst          = ($urandom_range(0, 149) == 0);
                step();
            end
            rst          = 1'b0;
            bus.in_valid = 1'b0;
            repeat (20) step();
            fin = 1'b1;
        end
    end

    int m_err = 0, m_chk = 0;

    initial begin
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (cfg[0].fin && cfg[1].fin) break;
        end
        m_chk++;
        if (!(cfg[0].fin && cfg[1].fin)) begin
            m_err++;
            $display("FAIL timeout: fin0=%0d fin1=%0d expected 1 1", cfg[0].fin, cfg[1].fin);
        end
        $display("Result: errors=%0d of %0d checks",
                 m_err + cfg[0].errs + cfg[0].cerr + cfg[1].errs + cfg[1].cerr,
                 m_chk + cfg[0].chks + cfg[0].cchk + cfg[1].chks + cfg[1].cchk);
        $finish;
    end
endmodule
